// File: rtl/xillybus_loopback_responder_pkg.sv
// Shared types and defaults for the 32-bit Xillybus loopback responder.
package xillybus_loopback_responder_pkg;
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] XOR_MASK_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STREAM = 3'd1,
    S_DRAIN  = 3'd2,
    S_EOF    = 3'd3,
    S_FLUSH  = 3'd4
  } state_t;
endpackage

// File: rtl/xillybus_loopback_responder_if.sv
// Xillybus 32-bit write/read stream pair as seen between xillybus_core and the user logic.
interface xillybus_loopback_responder_if;
  import xillybus_loopback_responder_pkg::*;

  logic              user_w_write_32_wren;
  logic [DATA_W-1:0] user_w_write_32_data;
  logic              user_w_write_32_full;
  logic              user_w_write_32_open;
  logic              user_r_read_32_rden;
  logic [DATA_W-1:0] user_r_read_32_data;
  logic              user_r_read_32_empty;
  logic              user_r_read_32_eof;
  logic              user_r_read_32_open;

  modport master (
    output user_w_write_32_wren, user_w_write_32_data, user_w_write_32_open,
    output user_r_read_32_rden, user_r_read_32_open,
    input  user_w_write_32_full, user_r_read_32_data, user_r_read_32_empty,
    input  user_r_read_32_eof
  );

  modport slave (
    input  user_w_write_32_wren, user_w_write_32_data, user_w_write_32_open,
    input  user_r_read_32_rden, user_r_read_32_open,
    output user_w_write_32_full, user_r_read_32_data, user_r_read_32_empty,
    output user_r_read_32_eof
  );
endinterface

// File: rtl/xillybus_loopback_responder_fifo_mem.sv
// Simple dual-port RAM: synchronous write, registered read, array left unreset.
module loopback_fifo_mem #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/xillybus_loopback_responder.sv
// Loops host writes back to the read stream in order and raises EOF once a closed write file drains.
module xillybus_loopback_responder
  import xillybus_loopback_responder_pkg::*;
#(
  parameter int               DEPTH_LOG2 = 9,
  parameter logic [DATA_W-1:0] XOR_MASK  = XOR_MASK_DEFAULT
) (
  input  logic                  bus_clk,
  input  logic                  trn_reset_n,
  input  logic                  quiesce,
  xillybus_loopback_responder_if.slave bus,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic                  overflow_err
);
  localparam int PTR_W = DEPTH_LOG2 + 1;
  localparam logic [PTR_W-1:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

  state_t            state_q, state_nxt;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, fill_nxt;
  logic              full_q, empty_q, full_nxt, empty_nxt;
  logic              have_data, overflow_q, write_open_q;
  logic              wr_acc, rd_acc, flush, open_rise, closing;
  logic [DATA_W-1:0] ram_q;

  loopback_fifo_mem #(.ADDR_W(DEPTH_LOG2), .DATA_W(DATA_W)) u_mem (
    .clk     (bus_clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[DEPTH_LOG2-1:0]),
    .wr_data (bus.user_w_write_32_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr[DEPTH_LOG2-1:0]),
    .rd_data (ram_q)
  );

  // Flags are computed from the post-edge pointers so full/empty are exact without lookahead.
  always_comb begin
    flush      = (state_q == S_FLUSH) || (quiesce && state_q == S_IDLE);
    wr_acc     = bus.user_w_write_32_wren && !full_q && !quiesce;
    rd_acc     = bus.user_r_read_32_rden && !empty_q && !flush;
    open_rise  = bus.user_w_write_32_open && !write_open_q;
    wr_ptr_nxt = wr_ptr + PTR_W'(wr_acc);
    rd_ptr_nxt = flush ? wr_ptr : rd_ptr + PTR_W'(rd_acc);
    fill_nxt   = wr_ptr_nxt - rd_ptr_nxt;

    state_nxt = state_q;
    if (quiesce) begin
      state_nxt = (state_q == S_IDLE || state_q == S_FLUSH) ? S_IDLE : S_FLUSH;
    end else begin
      case (state_q)
        S_IDLE:   if (open_rise) state_nxt = S_STREAM;
        S_STREAM: if (!bus.user_w_write_32_open) state_nxt = S_DRAIN;
        S_DRAIN: begin
          if (open_rise) state_nxt = S_STREAM;
          else if (fill_nxt == '0 && bus.user_r_read_32_open) state_nxt = S_EOF;
        end
        S_EOF:    if (!bus.user_r_read_32_open) state_nxt = S_FLUSH;
        S_FLUSH:  state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end

    closing   = (state_nxt == S_EOF) || (state_nxt == S_FLUSH);
    full_nxt  = quiesce || closing || (fill_nxt == DEPTH);
    empty_nxt = quiesce || closing || (fill_nxt == '0);
  end

  always_ff @(posedge bus_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      state_q      <= S_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      full_q       <= 1'b1;
      empty_q      <= 1'b1;
      have_data    <= 1'b0;
      overflow_q   <= 1'b0;
      write_open_q <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      full_q       <= full_nxt;
      empty_q      <= empty_nxt;
      have_data    <= have_data || rd_acc;
      overflow_q   <= overflow_q || (bus.user_w_write_32_wren && full_q);
      write_open_q <= bus.user_w_write_32_open;
    end
  end

  // The RAM output register has no reset, so read data is masked to zero until the first read.
  assign bus.user_r_read_32_data  = have_data ? (ram_q ^ XOR_MASK) : '0;
  assign bus.user_w_write_32_full = full_q;
  assign bus.user_r_read_32_empty = empty_q;
  assign bus.user_r_read_32_eof   = (state_q == S_EOF);
  assign fill_level               = wr_ptr - rd_ptr;
  assign overflow_err             = overflow_q;
endmodule

// File: tb/tb_xillybus_loopback_responder.sv
// Directed bench for the Xillybus loopback responder: plain-loopback instance plus an inverting-mask instance.
module tb_xillybus_loopback_responder;
  localparam int DL2 = 9;

  logic         clk, trn_reset_n, quiesce, quiesce_x;
  logic [DL2:0] fill_level, fill_level_x;
  logic         overflow_err, overflow_err_x;
  int           checks = 0;
  int           passed = 0;

  xillybus_loopback_responder_if bus();
  xillybus_loopback_responder_if bus_x();

  xillybus_loopback_responder #(.DEPTH_LOG2(DL2), .XOR_MASK(32'h0000_0000)) dut (
    .bus_clk(clk), .trn_reset_n(trn_reset_n), .quiesce(quiesce), .bus(bus),
    .fill_level(fill_level), .overflow_err(overflow_err)
  );

  xillybus_loopback_responder #(.DEPTH_LOG2(DL2), .XOR_MASK(32'hFFFF_FFFF)) dut_x (
    .bus_clk(clk), .trn_reset_n(trn_reset_n), .quiesce(quiesce_x), .bus(bus_x),
    .fill_level(fill_level_x), .overflow_err(overflow_err_x)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [31:0] d);
    bus.user_w_write_32_wren = 1'b1;
    bus.user_w_write_32_data = d;
    tick();
    bus.user_w_write_32_wren = 1'b0;
  endtask

  task automatic test_reset();
    trn_reset_n = 1'b0;
    tick();
    tick();
    checks++; if (bus.user_w_write_32_full !== 1'b1) $display("[TB] FAIL reset_full: got %b want 1", bus.user_w_write_32_full); else passed++;
    checks++; if (bus.user_r_read_32_empty !== 1'b1) $display("[TB] FAIL reset_empty: got %b want 1", bus.user_r_read_32_empty); else passed++;
    checks++; if (bus.user_r_read_32_eof !== 1'b0) $display("[TB] FAIL reset_eof: got %b want 0", bus.user_r_read_32_eof); else passed++;
    checks++; if (bus.user_r_read_32_data !== 32'h0) $display("[TB] FAIL reset_data: got %h want 0", bus.user_r_read_32_data); else passed++;
    checks++; if (fill_level !== '0) $display("[TB] FAIL reset_fill: got %0d want 0", fill_level); else passed++;
    checks++; if (overflow_err !== 1'b0) $display("[TB] FAIL reset_ovf: got %b want 0", overflow_err); else passed++;
    checks++; if (bus_x.user_r_read_32_data !== 32'h0) $display("[TB] FAIL reset_data_x: got %h want 0", bus_x.user_r_read_32_data); else passed++;
    trn_reset_n = 1'b1;
    tick();
    tick();
    checks++; if (bus.user_w_write_32_full !== 1'b0) $display("[TB] FAIL idle_full: got %b want 0", bus.user_w_write_32_full); else passed++;
  endtask

  task automatic test_basic_loopback();
    bus.user_w_write_32_open = 1'b1;
    tick();
    write_word(32'h1);
    write_word(32'h2);
    write_word(32'h3);
    checks++; if (fill_level !== 10'd3) $display("[TB] FAIL basic_fill: got %0d want 3", fill_level); else passed++;
    bus.user_r_read_32_open = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus.user_r_read_32_rden = 1'b1;
      tick();
      bus.user_r_read_32_rden = 1'b0;
      checks++; if (bus.user_r_read_32_data !== 32'(i)) $display("[TB] FAIL basic_data%0d: got %h want %h", i, bus.user_r_read_32_data, 32'(i)); else passed++;
    end
    checks++; if (bus.user_r_read_32_empty !== 1'b1) $display("[TB] FAIL basic_empty: got %b want 1", bus.user_r_read_32_empty); else passed++;
    checks++; if (bus.user_r_read_32_eof !== 1'b0) $display("[TB] FAIL basic_eof: got %b want 0", bus.user_r_read_32_eof); else passed++;
  endtask

  task automatic test_eof();
    write_word(32'hA5A5_A5A5);
    bus.user_w_write_32_open = 1'b0;
    tick();
    tick();
    checks++; if (bus.user_r_read_32_eof !== 1'b0) $display("[TB] FAIL drain_eof: got %b want 0", bus.user_r_read_32_eof); else passed++;
    checks++; if (bus.user_r_read_32_empty !== 1'b0) $display("[TB] FAIL drain_empty: got %b want 0", bus.user_r_read_32_empty); else passed++;
    bus.user_r_read_32_rden = 1'b1;
    tick();
    bus.user_r_read_32_rden = 1'b0;
    checks++; if (bus.user_r_read_32_data !== 32'hA5A5_A5A5) $display("[TB] FAIL eof_data: got %h want a5a5a5a5", bus.user_r_read_32_data); else passed++;
    checks++; if (bus.user_r_read_32_empty !== 1'b1) $display("[TB] FAIL eof_empty: got %b want 1", bus.user_r_read_32_empty); else passed++;
    checks++; if (bus.user_r_read_32_eof !== 1'b1) $display("[TB] FAIL eof_set: got %b want 1", bus.user_r_read_32_eof); else passed++;
    bus.user_r_read_32_open = 1'b0;
    tick();
    tick();
    checks++; if (bus.user_r_read_32_eof !== 1'b0) $display("[TB] FAIL eof_clear: got %b want 0", bus.user_r_read_32_eof); else passed++;
    checks++; if (fill_level !== '0) $display("[TB] FAIL eof_fill: got %0d want 0", fill_level); else passed++;
    checks++; if (bus.user_w_write_32_full !== 1'b0) $display("[TB] FAIL eof_idle_full: got %b want 0", bus.user_w_write_32_full); else passed++;
  endtask

  task automatic test_full_overflow();
    int bad;
    bus.user_w_write_32_open = 1'b1;
    tick();
    bus.user_w_write_32_wren = 1'b1;
    for (int i = 0; i < 512; i++) begin
      bus.user_w_write_32_data = 32'(i);
      tick();
      if (i == 510) begin
        checks++; if (bus.user_w_write_32_full !== 1'b0) $display("[TB] FAIL full_early: got %b want 0", bus.user_w_write_32_full); else passed++;
      end
    end
    bus.user_w_write_32_wren = 1'b0;
    checks++; if (bus.user_w_write_32_full !== 1'b1) $display("[TB] FAIL full_512: got %b want 1", bus.user_w_write_32_full); else passed++;
    checks++; if (fill_level !== 10'd512) $display("[TB] FAIL fill_512: got %0d want 512", fill_level); else passed++;
    write_word(32'd999);
    checks++; if (overflow_err !== 1'b1) $display("[TB] FAIL ovf_set: got %b want 1", overflow_err); else passed++;
    checks++; if (fill_level !== 10'd512) $display("[TB] FAIL ovf_fill: got %0d want 512", fill_level); else passed++;
    bus.user_r_read_32_open = 1'b1;
    bad = 0;
    bus.user_r_read_32_rden = 1'b1;
    for (int i = 0; i < 512; i++) begin
      tick();
      if (bus.user_r_read_32_data !== 32'(i)) bad++;
    end
    bus.user_r_read_32_rden = 1'b0;
    checks++; if (bad !== 0) $display("[TB] FAIL wrap_order: got %0d bad words want 0", bad); else passed++;
    checks++; if (bus.user_r_read_32_empty !== 1'b1) $display("[TB] FAIL wrap_empty: got %b want 1", bus.user_r_read_32_empty); else passed++;
    checks++; if (fill_level !== '0) $display("[TB] FAIL wrap_fill: got %0d want 0", fill_level); else passed++;
  endtask

  task automatic test_back_to_back();
    int bad_data, bad_fill;
    for (int i = 0; i < 5; i++) write_word(32'(1000 + i));
    bad_data = 0;
    bad_fill = 0;
    bus.user_w_write_32_wren = 1'b1;
    bus.user_r_read_32_rden  = 1'b1;
    for (int k = 0; k < 100; k++) begin
      bus.user_w_write_32_data = 32'(1005 + k);
      tick();
      if (bus.user_r_read_32_data !== 32'(1000 + k)) bad_data++;
      if (fill_level !== 10'd5) bad_fill++;
    end
    bus.user_w_write_32_wren = 1'b0;
    bus.user_r_read_32_rden  = 1'b0;
    checks++; if (bad_data !== 0) $display("[TB] FAIL b2b_data: got %0d bad words want 0", bad_data); else passed++;
    checks++; if (bad_fill !== 0) $display("[TB] FAIL b2b_fill: got %0d bad cycles want 0", bad_fill); else passed++;
    checks++; if (fill_level !== 10'd5) $display("[TB] FAIL b2b_fill_end: got %0d want 5", fill_level); else passed++;
  endtask

  task automatic test_quiesce();
    for (int i = 0; i < 5; i++) write_word(32'(2000 + i));
    checks++; if (fill_level !== 10'd10) $display("[TB] FAIL q_fill10: got %0d want 10", fill_level); else passed++;
    quiesce = 1'b1;
    tick();
    checks++; if (bus.user_w_write_32_full !== 1'b1) $display("[TB] FAIL q_full: got %b want 1", bus.user_w_write_32_full); else passed++;
    checks++; if (bus.user_r_read_32_empty !== 1'b1) $display("[TB] FAIL q_empty: got %b want 1", bus.user_r_read_32_empty); else passed++;
    checks++; if (bus.user_r_read_32_eof !== 1'b0) $display("[TB] FAIL q_eof: got %b want 0", bus.user_r_read_32_eof); else passed++;
    tick();
    tick();
    quiesce = 1'b0;
    tick();
    checks++; if (fill_level !== '0) $display("[TB] FAIL q_fill0: got %0d want 0", fill_level); else passed++;
    checks++; if (bus.user_w_write_32_full !== 1'b0) $display("[TB] FAIL q_full_release: got %b want 0", bus.user_w_write_32_full); else passed++;
  endtask

  task automatic test_async_reset();
    write_word(32'h7);
    write_word(32'h8);
    bus.user_r_read_32_rden = 1'b1;
    tick();
    bus.user_r_read_32_rden = 1'b0;
    checks++; if (bus.user_r_read_32_data !== 32'h7) $display("[TB] FAIL pre_rst_data: got %h want 7", bus.user_r_read_32_data); else passed++;
    #2;
    trn_reset_n = 1'b0;
    #1;
    checks++; if (bus.user_w_write_32_full !== 1'b1) $display("[TB] FAIL arst_full: got %b want 1", bus.user_w_write_32_full); else passed++;
    checks++; if (bus.user_r_read_32_empty !== 1'b1) $display("[TB] FAIL arst_empty: got %b want 1", bus.user_r_read_32_empty); else passed++;
    checks++; if (bus.user_r_read_32_eof !== 1'b0) $display("[TB] FAIL arst_eof: got %b want 0", bus.user_r_read_32_eof); else passed++;
    checks++; if (bus.user_r_read_32_data !== 32'h0) $display("[TB] FAIL arst_data: got %h want 0", bus.user_r_read_32_data); else passed++;
    checks++; if (fill_level !== '0) $display("[TB] FAIL arst_fill: got %0d want 0", fill_level); else passed++;
    checks++; if (overflow_err !== 1'b0) $display("[TB] FAIL arst_ovf: got %b want 0", overflow_err); else passed++;
    trn_reset_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_xor_mask();
    bus_x.user_w_write_32_open = 1'b1;
    tick();
    bus_x.user_w_write_32_wren = 1'b1;
    bus_x.user_w_write_32_data = 32'h0000_00FF;
    tick();
    bus_x.user_w_write_32_wren = 1'b0;
    bus_x.user_r_read_32_open = 1'b1;
    bus_x.user_r_read_32_rden = 1'b1;
    tick();
    bus_x.user_r_read_32_rden = 1'b0;
    checks++; if (bus_x.user_r_read_32_data !== 32'hFFFF_FF00) $display("[TB] FAIL xor_data: got %h want ffffff00", bus_x.user_r_read_32_data); else passed++;
    checks++; if (fill_level_x !== '0) $display("[TB] FAIL xor_fill: got %0d want 0", fill_level_x); else passed++;
  endtask

  initial begin
    trn_reset_n = 1'b1;
    quiesce     = 1'b0;
    quiesce_x   = 1'b0;
    bus.user_w_write_32_wren   = 1'b0;
    bus.user_w_write_32_data   = '0;
    bus.user_w_write_32_open   = 1'b0;
    bus.user_r_read_32_rden    = 1'b0;
    bus.user_r_read_32_open    = 1'b0;
    bus_x.user_w_write_32_wren = 1'b0;
    bus_x.user_w_write_32_data = '0;
    bus_x.user_w_write_32_open = 1'b0;
    bus_x.user_r_read_32_rden  = 1'b0;
    bus_x.user_r_read_32_open  = 1'b0;
    #2;
    test_reset();
    test_basic_loopback();
    test_eof();
    test_full_overflow();
    test_back_to_back();
    test_quiesce();
    test_async_reset();
    test_xor_mask();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
